// File: rtl/fpu_add_sub_requester_if.sv
// Start/clear handshake plus operand and result bus between the requester
// and the floating-point add/subtract unit.
interface fpu_add_sub_requester_if #(
    parameter int W = 32
);
    logic         fpu_beg_FSM;
    logic         fpu_rst_FSM;
    logic [W-1:0] fpu_Data_X;
    logic [W-1:0] fpu_Data_Y;
    logic         fpu_add_subt;
    logic [1:0]   fpu_r_mode;
    logic         fpu_ready;
    logic [W-1:0] fpu_result;
    logic         fpu_overflow;
    logic         fpu_underflow;

    modport master (
        output fpu_beg_FSM, fpu_rst_FSM, fpu_Data_X, fpu_Data_Y, fpu_add_subt, fpu_r_mode,
        input  fpu_ready, fpu_result, fpu_overflow, fpu_underflow
    );

    modport slave (
        input  fpu_beg_FSM, fpu_rst_FSM, fpu_Data_X, fpu_Data_Y, fpu_add_subt, fpu_r_mode,
        output fpu_ready, fpu_result, fpu_overflow, fpu_underflow
    );
endinterface

// File: rtl/fpu_add_sub_requester.sv
// Single-outstanding sequencer driving the add/subtract unit: launch, wait with
// watchdog, capture, clear, then present the result on a valid/ready port.
module fpu_add_sub_requester #(
    parameter int W       = 32,
    parameter int TIMEOUT = 64,
    parameter int TW      = 7
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [W-1:0]            req_x,
    input  logic [W-1:0]            req_y,
    input  logic                    req_op,
    input  logic [1:0]              req_rmode,
    fpu_add_sub_requester_if.master fpu,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [W-1:0]            rsp_result,
    output logic                    rsp_overflow,
    output logic                    rsp_underflow,
    output logic                    rsp_timeout,
    output logic                    busy
);

    typedef enum logic [2:0] {
        ST_INIT   = 3'd0,
        ST_IDLE   = 3'd1,
        ST_LAUNCH = 3'd2,
        ST_WAIT   = 3'd3,
        ST_CLEAR  = 3'd4,
        ST_RESP   = 3'd5
    } state_t;

    localparam logic [TW-1:0] CNT_LAST = TW'(TIMEOUT - 1);

    state_t        state_r;
    logic [TW-1:0] wdog_cnt_r;

    // Sequencer FSM; every output is a register updated on the transition into its state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r           <= ST_INIT;
            wdog_cnt_r        <= {TW{1'b0}};
            req_ready         <= 1'b0;
            busy              <= 1'b1;
            fpu.fpu_beg_FSM   <= 1'b0;
            fpu.fpu_rst_FSM   <= 1'b0;
            fpu.fpu_Data_X    <= {W{1'b0}};
            fpu.fpu_Data_Y    <= {W{1'b0}};
            fpu.fpu_add_subt  <= 1'b0;
            fpu.fpu_r_mode    <= 2'b00;
            rsp_valid         <= 1'b0;
            rsp_result        <= {W{1'b0}};
            rsp_overflow      <= 1'b0;
            rsp_underflow     <= 1'b0;
            rsp_timeout       <= 1'b0;
        end else begin
            case (state_r)
                // The clear pulse flushes whatever the unit was doing when reset hit.
                ST_INIT: begin
                    if (fpu.fpu_rst_FSM) begin
                        fpu.fpu_rst_FSM <= 1'b0;
                        req_ready       <= 1'b1;
                        busy            <= 1'b0;
                        state_r         <= ST_IDLE;
                    end else begin
                        fpu.fpu_rst_FSM <= 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (req_valid) begin
                        fpu.fpu_Data_X   <= req_x;
                        fpu.fpu_Data_Y   <= req_y;
                        fpu.fpu_add_subt <= req_op;
                        fpu.fpu_r_mode   <= req_rmode;
                        fpu.fpu_beg_FSM  <= 1'b1;
                        req_ready        <= 1'b0;
                        busy             <= 1'b1;
                        state_r          <= ST_LAUNCH;
                    end
                end
                ST_LAUNCH: begin
                    fpu.fpu_beg_FSM <= 1'b0;
                    wdog_cnt_r      <= {TW{1'b0}};
                    state_r         <= ST_WAIT;
                end
                // A ready arriving on the last watchdog cycle still counts as a normal result.
                ST_WAIT: begin
                    if (fpu.fpu_ready) begin
                        rsp_result      <= fpu.fpu_result;
                        rsp_overflow    <= fpu.fpu_overflow;
                        rsp_underflow   <= fpu.fpu_underflow;
                        rsp_timeout     <= 1'b0;
                        fpu.fpu_rst_FSM <= 1'b1;
                        state_r         <= ST_CLEAR;
                    end else if (wdog_cnt_r == CNT_LAST) begin
                        rsp_result      <= {W{1'b0}};
                        rsp_overflow    <= 1'b0;
                        rsp_underflow   <= 1'b0;
                        rsp_timeout     <= 1'b1;
                        fpu.fpu_rst_FSM <= 1'b1;
                        state_r         <= ST_CLEAR;
                    end else begin
                        wdog_cnt_r <= wdog_cnt_r + TW'(1);
                    end
                end
                ST_CLEAR: begin
                    fpu.fpu_rst_FSM <= 1'b0;
                    rsp_valid       <= 1'b1;
                    state_r         <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        busy      <= 1'b0;
                        state_r   <= ST_IDLE;
                    end
                end
                default: begin
                    req_ready       <= 1'b0;
                    busy            <= 1'b1;
                    fpu.fpu_beg_FSM <= 1'b0;
                    fpu.fpu_rst_FSM <= 1'b0;
                    rsp_valid       <= 1'b0;
                    state_r         <= ST_INIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_add_sub_requester.sv
// Bench for fpu_add_sub_requester: a fake add/subtract unit, a cycle-timing
// reference model with a per-cycle compare process, and directed plus random operations.
module tb_fpu_add_sub_requester;
    localparam int W       = 32;
    localparam int TIMEOUT = 64;
    localparam int TW      = 7;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid, req_ready, req_op;
    logic [W-1:0] req_x, req_y;
    logic [1:0]   req_rmode;
    logic         rsp_valid, rsp_ready, rsp_overflow, rsp_underflow, rsp_timeout, busy;
    logic [W-1:0] rsp_result;

    fpu_add_sub_requester_if #(.W(W)) bus ();

    fpu_add_sub_requester #(.W(W), .TIMEOUT(TIMEOUT), .TW(TW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_x(req_x), .req_y(req_y),
        .req_op(req_op), .req_rmode(req_rmode),
        .fpu(bus),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_overflow(rsp_overflow), .rsp_underflow(rsp_underflow),
        .rsp_timeout(rsp_timeout), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int total = 0;
    int bad = 0;
    int beg_cnt = 0;
    int clr_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
        total++;
        if (a !== e) begin
            bad++;
            if (bad <= 40) $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, a, e, cyc);
        end
    endtask

    // Reference model: cycles are labelled by cyc at the negedge; an accept seen in
    // cycle A puts beg in A+1, WAIT cycle j at A+2+j, clear at K+1, response from K+2.
    int          m_rel, m_acc, m_k, m_c;
    bit          m_act, m_kk, m_erv;
    logic [W-1:0] m_x, m_y, m_res;
    logic         m_op, m_ov, m_un, m_to;
    logic [1:0]   m_rm;

    always @(negedge clk) begin
        m_c = cyc;
        if (!rst) begin
            chk("rst_req_ready", req_ready, 0);   chk("rst_busy", busy, 1);
            chk("rst_beg", bus.fpu_beg_FSM, 0);   chk("rst_clr", bus.fpu_rst_FSM, 0);
            chk("rst_rsp_valid", rsp_valid, 0);   chk("rst_data_x", bus.fpu_Data_X, 0);
            chk("rst_data_y", bus.fpu_Data_Y, 0); chk("rst_op", bus.fpu_add_subt, 0);
            chk("rst_rmode", bus.fpu_r_mode, 0);  chk("rst_rsp_result", rsp_result, 0);
            chk("rst_rsp_flags", {rsp_overflow, rsp_underflow, rsp_timeout}, 0);
            m_rel = 0; m_act = 0; m_kk = 0;
            m_x = '0; m_y = '0; m_op = 1'b0; m_rm = 2'b00;
        end else begin
            if (m_rel < 2) begin
                chk("init_req_ready", req_ready, 0); chk("init_busy", busy, 1);
                chk("init_beg", bus.fpu_beg_FSM, 0);
                chk("init_clr", bus.fpu_rst_FSM, (m_rel == 1) ? 1 : 0);
                chk("init_rsp_valid", rsp_valid, 0);
                chk("init_rsp", {rsp_result, rsp_overflow, rsp_underflow, rsp_timeout}, 0);
            end else if (!m_act) begin
                chk("idle_req_ready", req_ready, 1); chk("idle_busy", busy, 0);
                chk("idle_beg", bus.fpu_beg_FSM, 0); chk("idle_clr", bus.fpu_rst_FSM, 0);
                chk("idle_rsp_valid", rsp_valid, 0);
            end else begin
                if (!m_kk && m_c >= m_acc + 2) begin
                    if (bus.fpu_ready) begin
                        m_kk = 1; m_k = m_c; m_res = bus.fpu_result;
                        m_ov = bus.fpu_overflow; m_un = bus.fpu_underflow; m_to = 1'b0;
                    end else if (m_c == m_acc + 1 + TIMEOUT) begin
                        m_kk = 1; m_k = m_c; m_res = '0; m_ov = 1'b0; m_un = 1'b0; m_to = 1'b1;
                    end
                end
                m_erv = m_kk && (m_c >= m_k + 2);
                chk("op_req_ready", req_ready, 0); chk("op_busy", busy, 1);
                chk("op_beg", bus.fpu_beg_FSM, (m_c == m_acc + 1) ? 1 : 0);
                chk("op_clr", bus.fpu_rst_FSM, (m_kk && m_c == m_k + 1) ? 1 : 0);
                chk("op_rsp_valid", rsp_valid, m_erv ? 1 : 0);
                if (m_erv) begin
                    chk("rsp_result", rsp_result, m_res);
                    chk("rsp_flags", {rsp_overflow, rsp_underflow, rsp_timeout}, {m_ov, m_un, m_to});
                end
            end
            if (m_rel >= 2) begin
                chk("data_x", bus.fpu_Data_X, m_x);      chk("data_y", bus.fpu_Data_Y, m_y);
                chk("add_subt", bus.fpu_add_subt, m_op); chk("r_mode", bus.fpu_r_mode, m_rm);
            end
            if (m_rel >= 2 && m_act && m_kk && m_c >= m_k + 2 && rsp_ready) begin
                m_act = 0;
            end else if (m_rel >= 2 && !m_act && req_valid) begin
                m_act = 1; m_acc = m_c; m_kk = 0;
                m_x = req_x; m_y = req_y; m_op = req_op; m_rm = req_rmode;
            end
            if (m_rel < 2) m_rel++;
        end
        if (bus.fpu_beg_FSM === 1'b1) beg_cnt++;
        if (bus.fpu_rst_FSM === 1'b1) clr_cnt++;
    end

    // One operation: request, fake-unit response after d WAIT cycles (never if d >= TIMEOUT),
    // optional stale ready during LAUNCH, then rsp_ready after hold extra cycles.
    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic op,
                          input logic [1:0] rm, input int d, input bit stale,
                          input logic [W-1:0] res, input logic ov, input logic un, input int hold,
                          output int acc_o, output int rv_o, output int rdy_o,
                          output logic [W-1:0] r_res, output logic [2:0] r_flags);
        int  n;
        bit  seen;
        acc_o = -1; rv_o = -1; rdy_o = -1; r_res = '0; r_flags = 3'b000;
        @(posedge clk); #1;
        req_valid = 1'b1; req_x = x; req_y = y; req_op = op; req_rmode = rm;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 50) begin n++; @(negedge clk); end
        chk("accept_wait", req_ready, 1);
        if (!req_ready) begin req_valid = 1'b0; return; end
        acc_o = cyc;
        @(posedge clk); #1;
        req_valid = 1'b0; req_x = $urandom; req_y = $urandom; req_op = 1'($urandom);
        if (stale) begin bus.fpu_ready = 1'b1; bus.fpu_result = ~res; end
        seen = 0;
        for (int j = 0; j < TIMEOUT + 8 && !seen; j++) begin
            @(posedge clk); #1;
            if (j >= d) begin
                bus.fpu_ready = 1'b1; bus.fpu_result = res;
                bus.fpu_overflow = ov; bus.fpu_underflow = un;
                if (rdy_o < 0) rdy_o = cyc;
            end else begin
                bus.fpu_ready = 1'b0; bus.fpu_result = $urandom;
                bus.fpu_overflow = 1'($urandom); bus.fpu_underflow = 1'($urandom);
            end
            @(negedge clk);
            if (bus.fpu_rst_FSM) seen = 1;
        end
        chk("clear_wait", bus.fpu_rst_FSM, 1);
        @(posedge clk); #1;
        bus.fpu_ready = 1'b0; bus.fpu_overflow = 1'b0; bus.fpu_underflow = 1'b0;
        bus.fpu_result = $urandom;
        n = 0;
        @(negedge clk);
        while (!rsp_valid && n < 10) begin n++; @(negedge clk); end
        chk("rsp_wait", rsp_valid, 1);
        rv_o = cyc; r_res = rsp_result; r_flags = {rsp_overflow, rsp_underflow, rsp_timeout};
        repeat (hold) @(posedge clk);
        @(posedge clk); #1; rsp_ready = 1'b1;
        @(posedge clk); #1; rsp_ready = 1'b0;
    endtask

    int          acc, rv, rdy, b0, c0, d, n;
    logic [W-1:0] res, rres;
    logic [2:0]   rfl;
    logic         ov, un;

    initial begin
        #500000;
        $display("FAIL global_watchdog: bench did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b0; req_valid = 1'b0; req_x = '0; req_y = '0; req_op = 1'b0; req_rmode = 2'b00;
        rsp_ready = 1'b0; bus.fpu_ready = 1'b0; bus.fpu_result = '0;
        bus.fpu_overflow = 1'b0; bus.fpu_underflow = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_busy", busy, 1); chk("reset_req_ready", req_ready, 0);
        @(posedge clk); #1; rst = 1'b1;
        @(negedge clk); chk("release_no_pulse_yet", bus.fpu_rst_FSM, 0);
        @(negedge clk); chk("init_pulse", bus.fpu_rst_FSM, 1);
        @(negedge clk); chk("init_done_clr", bus.fpu_rst_FSM, 0); chk("init_done_ready", req_ready, 1);

        // 1.0 + 2.0 with the unit ready after 10 WAIT cycles
        b0 = beg_cnt; c0 = clr_cnt;
        run_op(32'h3F800000, 32'h40000000, 1'b0, 2'b00, 10, 1'b0, 32'h40400000, 1'b0, 1'b0, 0,
               acc, rv, rdy, rres, rfl);
        chk("t1_result", rres, 32'h40400000); chk("t1_flags", rfl, 3'b000);
        chk("t1_valid_after_ready", 64'(rv - rdy), 2);
        chk("t1_beg_pulses", 64'(beg_cnt - b0), 1); chk("t1_clr_pulses", 64'(clr_cnt - c0), 1);

        // 3.0 - 1.0 with rsp_ready held low for 5 cycles
        run_op(32'h40400000, 32'h3F800000, 1'b1, 2'b01, 3, 1'b0, 32'h40000000, 1'b0, 1'b0, 4,
               acc, rv, rdy, rres, rfl);
        chk("t2_result", rres, 32'h40000000);
        @(negedge clk); chk("t2_idle_after_accept", req_ready, 1);

        // unit never answers: watchdog abort
        c0 = clr_cnt;
        run_op(32'h11111111, 32'h22222222, 1'b0, 2'b10, 1000, 1'b0, 32'h33333333, 1'b1, 1'b1, 0,
               acc, rv, rdy, rres, rfl);
        chk("t3_valid_latency", 64'(rv - acc), 67);
        chk("t3_result", rres, 0); chk("t3_flags", rfl, 3'b001);
        chk("t3_clr_pulses", 64'(clr_cnt - c0), 1);

        // ready on the very last watchdog cycle wins over the timeout
        run_op(32'h7F000000, 32'h7F000000, 1'b0, 2'b00, TIMEOUT - 1, 1'b0, 32'h7F800000, 1'b1, 1'b0, 1,
               acc, rv, rdy, rres, rfl);
        chk("t4_result", rres, 32'h7F800000); chk("t4_flags", rfl, 3'b100);
        chk("t4_valid_latency", 64'(rv - acc), 67);

        // stale ready during LAUNCH is ignored; capture on first WAIT cycle
        run_op(32'h41200000, 32'h3F000000, 1'b1, 2'b11, 0, 1'b1, 32'h41180000, 1'b0, 1'b1, 0,
               acc, rv, rdy, rres, rfl);
        chk("t6_result", rres, 32'h41180000); chk("t6_flags", rfl, 3'b010);
        chk("t6_valid_latency", 64'(rv - acc), 4);

        // reset asserted while waiting on the unit
        @(posedge clk); #1;
        req_valid = 1'b1; req_x = 32'h12345678; req_y = 32'h9ABCDEF0; req_op = 1'b1; req_rmode = 2'b10;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 50) begin n++; @(negedge clk); end
        chk("t5_accept", req_ready, 1);
        @(posedge clk); #1; req_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1; rst = 1'b0;
        @(negedge clk);
        chk("t5_busy", busy, 1); chk("t5_req_ready", req_ready, 0);
        chk("t5_data_x", bus.fpu_Data_X, 0); chk("t5_clr", bus.fpu_rst_FSM, 0);
        @(posedge clk); #1; rst = 1'b1;
        @(negedge clk);
        @(negedge clk); chk("t5_init_pulse", bus.fpu_rst_FSM, 1);
        @(negedge clk); chk("t5_ready_after", req_ready, 1);
        repeat (6) begin @(negedge clk); chk("t5_no_rsp", rsp_valid, 0); end

        // randomized operations against the model
        for (int i = 0; i < 40; i++) begin
            n = $urandom_range(0, 9);
            d = (n == 0) ? TIMEOUT + 5 : (n == 1) ? TIMEOUT - 1 : $urandom_range(0, 12);
            res = $urandom; ov = 1'($urandom); un = 1'($urandom);
            run_op($urandom, $urandom, 1'($urandom), 2'($urandom), d, 1'($urandom),
                   res, ov, un, $urandom_range(0, 3), acc, rv, rdy, rres, rfl);
            if (d <= TIMEOUT - 1) begin
                chk("rnd_result", rres, res); chk("rnd_flags", rfl, {ov, un, 1'b0});
            end else begin
                chk("rnd_to_result", rres, 0); chk("rnd_to_flags", rfl, 3'b001);
            end
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        repeat (4) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fpu_add_sub_requester.md
# fpu_add_sub_requester

Initiator-side sequencer for the floating-point add/subtract unit: accepts one operation request at a time on a valid/ready port and drives the unit's start handshake (`beg_FSM`, operands, `add_subt`, `r_mode`). It waits for `ready`, captures the IEEE result and the overflow/underflow flags, and clears the unit with a one-cycle `rst_FSM` pulse. The captured result is presented on a valid/ready response port. It sits between the natural-logarithm datapath control and the add/subtract unit, and includes a watchdog so a hung unit cannot stall the datapath.

## Interface
- `W`, 32, IEEE word width (32 single, 64 double)
- `TIMEOUT`, 64, maximum cycles waited in WAIT before abort (≥2)
- `TW`, 7, watchdog counter width; must satisfy 2^TW > TIMEOUT
- `clk`  in  1  clock; all logic on rising edge
- `rst`  in  1  reset, asynchronous and active-low
- `req_valid`  in  1  request present
- `req_ready`  out  1  request accepted when `req_valid && req_ready`
- `req_x`  in  W  operand X
- `req_y`  in  W  operand Y
- `req_op`  in  1  0 = add, 1 = subtract
- `req_rmode`  in  2  rounding mode, passed through
- `fpu_beg_FSM`  out  1  start pulse to the unit
- `fpu_rst_FSM`  out  1  clear pulse to the unit
- `fpu_Data_X`  out  W  registered operand X
- `fpu_Data_Y`  out  W  registered operand Y
- `fpu_add_subt`  out  1  registered op
- `fpu_r_mode`  out  2  registered rounding mode
- `fpu_ready`  in  1  unit done; held high until `rst_FSM`
- `fpu_result`  in  W  unit `final_result_ieee`
- `fpu_overflow`  in  1  unit overflow flag
- `fpu_underflow`  in  1  unit underflow flag
- `rsp_valid`  out  1  response present
- `rsp_ready`  in  1  consumer accepts response
- `rsp_result`  out  W  captured result
- `rsp_overflow`, `rsp_underflow`, `rsp_timeout`  out  1 each  captured flags
- `busy`  out  1  high in every state except IDLE

## Operation
- States: INIT, IDLE, LAUNCH, WAIT, CLEAR, RESP.
- INIT: entered on reset. `fpu_rst_FSM`=1 for exactly one cycle after reset release, which clears any unit operation interrupted by reset. Then IDLE.
- IDLE: `req_ready`=1. On handshake, register `req_x`, `req_y`, `req_op`, `req_rmode` into `fpu_*` and go to LAUNCH. Operand registers are written only on this handshake.
- LAUNCH: `fpu_beg_FSM`=1 for one cycle; watchdog counter cleared to 0; go to WAIT. `fpu_ready` is not sampled here.
- WAIT: if `fpu_ready`=1, capture `fpu_result`, `fpu_overflow` and `fpu_underflow`, clear `rsp_timeout`, and go to CLEAR. Otherwise increment the counter. When the counter equals TIMEOUT-1 with `fpu_ready`=0, capture result=0, overflow=0, underflow=0, `rsp_timeout`=1, and go to CLEAR.
- If `fpu_ready` and counter==TIMEOUT-1 occur in the same cycle, `fpu_ready` wins: normal capture, timeout=0.
- CLEAR: `fpu_rst_FSM`=1 for one cycle; go to RESP.
- RESP: `rsp_valid`=1. `rsp_*` are held stable until `rsp_ready`=1, then go to IDLE. No new request is accepted in RESP (single outstanding operation).
- `fpu_Data_X`/`Y`, `fpu_add_subt` and `fpu_r_mode` are stable from LAUNCH through CLEAR.
- Reset values: `req_ready`=0, `fpu_beg_FSM`=0, `fpu_rst_FSM`=0 (while `rst` is low), all `fpu_Data_*`, `fpu_add_subt`, `fpu_r_mode` = 0, `rsp_valid`=0, `rsp_*`=0, `busy`=1, state=INIT.
- Reset mid-operation: all state is discarded immediately and no response is issued. INIT then pulses `rst_FSM`.

## Timing
- All outputs are registered or decoded from the state register. There is no combinational path from any `fpu_*` or `rsp_ready` input to any output.
- Request accepted at edge 0: `fpu_beg_FSM` high in cycle 1 and WAIT from cycle 2.
- If `fpu_ready` is first sampled high in WAIT cycle k: `fpu_rst_FSM` is high in cycle k+1 and `rsp_valid` is high from cycle k+2.
- Timeout: `rsp_valid` rises TIMEOUT+3 cycles after the accepting edge.
- Back-to-back throughput: at minimum 5 cycles per operation plus the unit's latency.

## Test plan
- Add 0x3F800000 + 0x40000000, op=0, rmode=0, unit `ready` after 10 cycles → `rsp_result`=0x40400000, flags 0, one `beg_FSM` pulse, one `rst_FSM` pulse, `rsp_valid` 2 cycles after `ready`.
- Subtract 0x40400000 − 0x3F800000 with `rsp_ready` held low for 5 cycles → `rsp_result`=0x40000000 held stable, `req_ready`=0 throughout, IDLE one cycle after `rsp_ready`.
- Unit never raises `ready`, TIMEOUT=64 → `rsp_timeout`=1, result 0, `rsp_valid` at cycle 67 after acceptance, `rst_FSM` pulsed once.
- `ready` asserted exactly at counter=TIMEOUT-1 with result 0x7F800000 and overflow=1 → `rsp_timeout`=0, `rsp_overflow`=1, `rsp_result`=0x7F800000.
- `rst` asserted low during WAIT → all outputs at reset values immediately; after release, `fpu_rst_FSM` pulses 1 cycle, then `req_ready`=1 and no `rsp_valid` is issued.
- Stale `fpu_ready`=1 held during LAUNCH from the bench → ignored in LAUNCH; capture occurs on the first WAIT cycle only.
